// File: rtl/montacargas_gen.sv
// montacargas_gen: freight-lift controller for FLOORS stops with collective
// up/down scheduling, door dwell and a self-timed 2-digit display scan.
// Optional overweight hold (OVER state) is built when MONTACARGAS_SP_EN is
// defined; without it the sp input is ignored.
// Handshake note: there is no valid/ready traffic here. Every input is a
// level sampled on each rising clk edge, and every output is a register that
// changes only on that edge or on reset.
`timescale 1ns/1ps
module montacargas_gen #(
   parameter int FLOORS  = 4,
   parameter int FW      = 3,
   parameter int DWELL   = 4000000,
   parameter int MUX_DIV = 33333
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] call,
   input  logic [FLOORS-1:0] fc,
   input  logic              sp,
   output logic [1:0]        motor,
   output logic [1:0]        on,
   output logic [6:0]        seg,
   output logic [FW-1:0]     floor,
   output logic              busy,
   output logic [2:0]        dbg_state,
   output logic [FLOORS-1:0] dbg_req
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
   localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);
   localparam logic [6:0]    SEG_BLANK = 7'b0000000;
`ifdef MONTACARGAS_SP_EN
   localparam logic [6:0]    SEG_S = 7'b1101101;
   localparam logic [6:0]    SEG_P = 7'b1110011;
`endif

   typedef enum logic [2:0] {
      S_HOMING = 3'd0,
      S_IDLE   = 3'd1,
      S_UP     = 3'd2,
      S_DOWN   = 3'd3,
      S_DWELL  = 3'd4,
      S_OVER   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [FLOORS-1:0]   req_q, req_d;
   logic [FW-1:0]       floor_q, floor_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                dir_q, dir_d;      // last travel direction, 1 = up
   logic [MW-1:0]       mux_q, mux_d;
   logic [1:0]          on_q, on_d;
   logic [6:0]          seg_q, seg_d;
   logic [1:0]          motor_q, motor_d;
   logic                busy_q, busy_d;

   logic                fc_valid;
   logic [FW-1:0]       fc_idx;
   logic [FLOORS-1:0]   floor_oh;
   logic                ahead_up, ahead_dn;
   logic [FLOORS-1:0]   set_m, clr_m;
   logic                sp_hold;
   logic [6:0]          left_seg, right_seg;
   int                  next_up, next_dn;

`ifdef MONTACARGAS_SP_EN
   assign sp_hold = sp;
`else
   logic unused_sp;
   assign unused_sp = sp;
   assign sp_hold   = 1'b0;
`endif

   // Digit pattern for floor index idx (shown as idx+1), segments g..a.
   function automatic logic [6:0] digit_code(input int idx);
      case (idx)
         0:       digit_code = 7'b0000110;
         1:       digit_code = 7'b1011011;
         2:       digit_code = 7'b1001111;
         3:       digit_code = 7'b1100110;
         4:       digit_code = 7'b1101101;
         5:       digit_code = 7'b1111101;
         6:       digit_code = 7'b0000111;
         7:       digit_code = 7'b1111111;
         default: digit_code = SEG_BLANK;
      endcase
   endfunction

   // Limit-switch decode: only a one-hot pattern identifies a floor.
   always_comb begin : fc_decode
      fc_valid = $onehot(fc);
      fc_idx   = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (fc[i]) fc_idx = FW'(i);
      end
      floor_d = fc_valid ? fc_idx : floor_q;
   end

   // Pending-request summary relative to the confirmed floor.
   always_comb begin : ahead_calc
      ahead_up = 1'b0;
      ahead_dn = 1'b0;
      floor_oh = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i > int'(floor_q) && req_q[i]) ahead_up = 1'b1;
         if (i < int'(floor_q) && req_q[i]) ahead_dn = 1'b1;
         if (FW'(i) == floor_q) floor_oh[i] = 1'b1;
      end
   end

   // Scheduler next-state, dwell timer and request set/clear masks.
   always_comb begin : fsm_next
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      set_m   = call;
      clr_m   = '0;
      case (state_q)
         S_HOMING: begin
            if (fc[0]) begin
               state_d  = S_DWELL;
               cnt_d    = CNT_LOAD;
               dir_d    = 1'b0;
               clr_m[0] = 1'b1;
            end
         end
         S_IDLE: begin
            if (sp_hold) begin
               state_d = S_OVER;
            end else if (|(req_q & floor_oh)) begin
               clr_m   = floor_oh;
               state_d = S_DWELL;
               cnt_d   = CNT_LOAD;
            end else if (ahead_up) begin
               state_d = S_UP;
               dir_d   = 1'b1;
            end else if (ahead_dn) begin
               state_d = S_DOWN;
               dir_d   = 1'b0;
            end
         end
         // A call arriving on the same edge as the car counts as a request.
         S_UP: begin
            if (fc_valid && ((|(fc & (req_q | call))) || fc[FLOORS-1])) begin
               clr_m   = fc;
               state_d = S_DWELL;
               cnt_d   = CNT_LOAD;
            end
         end
         S_DOWN: begin
            if (fc_valid && ((|(fc & (req_q | call))) || fc[0])) begin
               clr_m   = fc;
               state_d = S_DWELL;
               cnt_d   = CNT_LOAD;
            end
         end
         S_DWELL: begin
            set_m = call & ~floor_oh;
            if (sp_hold) begin
               state_d = S_OVER;
            end else if (|(call & floor_oh)) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (dir_q && ahead_up) begin
               state_d = S_UP;
            end else if (!dir_q && ahead_dn) begin
               state_d = S_DOWN;
            end else if (ahead_dn) begin
               state_d = S_DOWN;
               dir_d   = 1'b0;
            end else if (ahead_up) begin
               state_d = S_UP;
               dir_d   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
`ifdef MONTACARGAS_SP_EN
         S_OVER: begin
            if (!sp) begin
               state_d = S_DWELL;
               cnt_d   = CNT_LOAD;
            end
         end
`endif
         default: state_d = S_HOMING;
      endcase
      // Clearing wins over a simultaneous call at the stop floor.
      req_d = (req_q | set_m) & ~clr_m;
   end

   // Display scan divider: alternate the lit digit every MUX_DIV cycles.
   always_comb begin : scan_next
      if (mux_q == MUX_LAST) begin
         mux_d = '0;
         on_d  = ~on_q;
      end else begin
         mux_d = mux_q + 1'b1;
         on_d  = on_q;
      end
   end

   // Registered outputs derived from the next state so they track it exactly.
   always_comb begin : outputs_next
      next_up = FLOORS - 1;
      next_dn = 0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (i > int'(floor_d) && req_d[i]) next_up = i;
      end
      for (int i = 0; i < FLOORS; i++) begin
         if (i < int'(floor_d) && req_d[i]) next_dn = i;
      end
      left_seg  = SEG_BLANK;
      right_seg = SEG_BLANK;
      motor_d   = 2'b00;
      case (state_d)
         S_HOMING: begin
            left_seg = digit_code(0);
            motor_d  = 2'b10;
         end
         S_UP: begin
            left_seg = digit_code(next_up);
            motor_d  = 2'b01;
         end
         S_DOWN: begin
            left_seg = digit_code(next_dn);
            motor_d  = 2'b10;
         end
         S_IDLE, S_DWELL: right_seg = digit_code(int'(floor_d));
`ifdef MONTACARGAS_SP_EN
         S_OVER: begin
            left_seg  = SEG_S;
            right_seg = SEG_P;
         end
`endif
         default: begin
            left_seg  = SEG_BLANK;
            right_seg = SEG_BLANK;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      seg_d  = (on_d == 2'b10) ? right_seg : left_seg;
   end

   // State and output registers; reset stops the motor immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_HOMING;
         req_q   <= '0;
         floor_q <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mux_q   <= '0;
         on_q    <= 2'b10;
         seg_q   <= SEG_BLANK;
         motor_q <= 2'b00;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         floor_q <= floor_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mux_q   <= mux_d;
         on_q    <= on_d;
         seg_q   <= seg_d;
         motor_q <= motor_d;
         busy_q  <= busy_d;
      end
   end

   assign motor     = motor_q;
   assign on        = on_q;
   assign seg       = seg_q;
   assign floor     = floor_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;
   assign dbg_req   = req_q;

endmodule

// File: tb/tb_montacargas_gen.sv
// tb_montacargas_gen: directed vector table plus hand sequences for the
// lift controller with FLOORS=4, DWELL=8, MUX_DIV=4.
`timescale 1ns/1ps
module tb_montacargas_gen;

   localparam logic [2:0] H = 3'd0, I = 3'd1, U = 3'd2, D = 3'd3, W = 3'd4, O = 3'd5;

   typedef struct {
      int         rep;
      logic [3:0] call;
      logic [3:0] fc;
      logic       sp;
      logic [2:0] st;
      logic [1:0] m;
      int         fl;
      logic       b;
      logic [3:0] req;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] call;
   logic [3:0] fc;
   logic       sp;
   logic [1:0] motor;
   logic [1:0] on;
   logic [6:0] seg;
   logic [2:0] floor;
   logic       busy;
   logic [2:0] dbg_state;
   logic [3:0] dbg_req;

   int   n_pass  = 0;
   int   n_total = 0;
   int   row_no  = 0;
   int   edges;
   vec_t vecs[$];

   // clock / reset block
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset) begin
      if (!reset) edges <= 0;
      else        edges <= edges + 1;
   end

   montacargas_gen #(.FLOORS(4), .FW(3), .DWELL(8), .MUX_DIV(4)) dut (
      .clk(clk), .reset(reset), .call(call), .fc(fc), .sp(sp),
      .motor(motor), .on(on), .seg(seg), .floor(floor), .busy(busy),
      .dbg_state(dbg_state), .dbg_req(dbg_req)
   );

   // expected display model
   function automatic logic [6:0] dig(input int i);
      case (i)
         0:       dig = 7'b0000110;
         1:       dig = 7'b1011011;
         2:       dig = 7'b1001111;
         3:       dig = 7'b1100110;
         default: dig = 7'b0000000;
      endcase
   endfunction

   function automatic logic [1:0] exp_on();
      exp_on = (((edges / 4) % 2) == 0) ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [6:0] exp_seg(input logic [2:0] st, input int f,
                                          input logic [3:0] rq, input logic [1:0] o);
      logic [6:0] l, r;
      int n;
      l = 7'b0000000;
      r = 7'b0000000;
      case (st)
         H: l = dig(0);
         I, W: r = dig(f);
         U: begin
            n = 3;
            for (int i = 3; i > f; i--) if (rq[i]) n = i;
            l = dig(n);
         end
         D: begin
            n = 0;
            for (int i = 0; i < f; i++) if (rq[i]) n = i;
            l = dig(n);
         end
         O: begin
            l = 7'b1101101;
            r = 7'b1110011;
         end
         default: ;
      endcase
      exp_seg = (o == 2'b10) ? r : l;
   endfunction

   // scoreboard
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: got %0h expected %0h", name, row_no, act, exp);
   endtask

   function automatic vec_t mk(input int rep, input logic [3:0] c, input logic [3:0] f,
                               input logic s, input logic [2:0] st, input logic [1:0] m,
                               input int fl, input logic b, input logic [3:0] rq);
      vec_t v;
      v.rep = rep; v.call = c; v.fc = f; v.sp = s; v.st = st;
      v.m = m; v.fl = fl; v.b = b; v.req = rq;
      return v;
   endfunction

   task automatic add(input int rep, input logic [3:0] c, input logic [3:0] f,
                      input logic s, input logic [2:0] st, input logic [1:0] m,
                      input int fl, input logic b, input logic [3:0] rq);
      vecs.push_back(mk(rep, c, f, s, st, m, fl, b, rq));
   endtask

   // driver: apply one row (possibly repeated), sample 1 ns after the edge
   task automatic run_row(input vec_t v);
      logic [1:0] eo;
      for (int r = 0; r < v.rep; r++) begin
         call = v.call;
         fc   = v.fc;
         sp   = v.sp;
         @(posedge clk);
         #1;
         row_no++;
         eo = exp_on();
         check("state", 16'(dbg_state), 16'(v.st));
         check("motor", 16'(motor), 16'(v.m));
         check("floor", 16'(floor), 16'(v.fl));
         check("busy",  16'(busy),  16'(v.b));
         check("req",   16'(dbg_req), 16'(v.req));
         check("on",    16'(on), 16'(eo));
         check("seg",   16'(seg), 16'(exp_seg(v.st, v.fl, v.req, eo)));
      end
   endtask

   task automatic run_all();
      foreach (vecs[k]) run_row(vecs[k]);
      vecs.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      call  = 4'b0000;
      fc    = 4'b0000;
      sp    = 1'b0;
      #12;
      check("rst_motor", 16'(motor), 16'h0);
      check("rst_on",    16'(on), 16'h2);
      check("rst_seg",   16'(seg), 16'h0);
      check("rst_floor", 16'(floor), 16'h0);
      check("rst_busy",  16'(busy), 16'h1);
      check("rst_req",   16'(dbg_req), 16'h0);
      check("rst_state", 16'(dbg_state), 16'(H));
      reset = 1'b1;

      // homing, dwell at floor 0, idle
      add(2, 4'b0000, 4'b0000, 0, H, 2'b10, 0, 1, 4'b0000);
      add(1, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0000);
      add(7, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0000);
      add(1, 4'b0000, 4'b0001, 0, I, 2'b00, 0, 0, 4'b0000);
      // call floor 3: pass 1 and 2 without stopping
      add(1, 4'b1000, 4'b0001, 0, I, 2'b00, 0, 0, 4'b1000);
      add(1, 4'b0000, 4'b0001, 0, U, 2'b01, 0, 1, 4'b1000);
      add(1, 4'b0000, 4'b0000, 0, U, 2'b01, 0, 1, 4'b1000);
      add(1, 4'b0000, 4'b0010, 0, U, 2'b01, 1, 1, 4'b1000);
      add(1, 4'b0000, 4'b0000, 0, U, 2'b01, 1, 1, 4'b1000);
      add(1, 4'b0000, 4'b0100, 0, U, 2'b01, 2, 1, 4'b1000);
      add(1, 4'b0000, 4'b0000, 0, U, 2'b01, 2, 1, 4'b1000);
      add(1, 4'b0000, 4'b1000, 0, W, 2'b00, 3, 1, 4'b0000);
      add(7, 4'b0000, 4'b1000, 0, W, 2'b00, 3, 1, 4'b0000);
      add(1, 4'b0000, 4'b1000, 0, I, 2'b00, 3, 0, 4'b0000);
      // back down to floor 0
      add(1, 4'b0001, 4'b1000, 0, I, 2'b00, 3, 0, 4'b0001);
      add(1, 4'b0000, 4'b1000, 0, D, 2'b10, 3, 1, 4'b0001);
      add(1, 4'b0000, 4'b0000, 0, D, 2'b10, 3, 1, 4'b0001);
      add(1, 4'b0000, 4'b0100, 0, D, 2'b10, 2, 1, 4'b0001);
      add(1, 4'b0000, 4'b0000, 0, D, 2'b10, 2, 1, 4'b0001);
      add(1, 4'b0000, 4'b0010, 0, D, 2'b10, 1, 1, 4'b0001);
      add(1, 4'b0000, 4'b0000, 0, D, 2'b10, 1, 1, 4'b0001);
      add(1, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0000);
      add(7, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0000);
      add(1, 4'b0000, 4'b0001, 0, I, 2'b00, 0, 0, 4'b0000);
      // up to 3, calls for 1 and 2 en route; arrival at 2 with call[2] held
      add(1, 4'b1000, 4'b0001, 0, I, 2'b00, 0, 0, 4'b1000);
      add(1, 4'b0000, 4'b0001, 0, U, 2'b01, 0, 1, 4'b1000);
      add(1, 4'b0000, 4'b0010, 0, U, 2'b01, 1, 1, 4'b1000);
      add(1, 4'b0110, 4'b0000, 0, U, 2'b01, 1, 1, 4'b1110);
      add(1, 4'b0100, 4'b0100, 0, W, 2'b00, 2, 1, 4'b1010);
      add(7, 4'b0000, 4'b0100, 0, W, 2'b00, 2, 1, 4'b1010);
      add(1, 4'b0000, 4'b0100, 0, U, 2'b01, 2, 1, 4'b1010);
      add(1, 4'b0000, 4'b0000, 0, U, 2'b01, 2, 1, 4'b1010);
      add(1, 4'b0000, 4'b1000, 0, W, 2'b00, 3, 1, 4'b0010);
      add(7, 4'b0000, 4'b1000, 0, W, 2'b00, 3, 1, 4'b0010);
      add(1, 4'b0000, 4'b1000, 0, D, 2'b10, 3, 1, 4'b0010);
      add(1, 4'b0000, 4'b1100, 0, D, 2'b10, 3, 1, 4'b0010);
      add(1, 4'b0000, 4'b0100, 0, D, 2'b10, 2, 1, 4'b0010);
      add(1, 4'b0000, 4'b0000, 0, D, 2'b10, 2, 1, 4'b0010);
      add(1, 4'b0000, 4'b0010, 0, W, 2'b00, 1, 1, 4'b0000);
      // dwell extension by call at the current floor
      add(3, 4'b0000, 4'b0010, 0, W, 2'b00, 1, 1, 4'b0000);
      add(1, 4'b0010, 4'b0010, 0, W, 2'b00, 1, 1, 4'b0000);
      add(7, 4'b0000, 4'b0010, 0, W, 2'b00, 1, 1, 4'b0000);
      add(1, 4'b0000, 4'b0010, 0, I, 2'b00, 1, 0, 4'b0000);
`ifndef MONTACARGAS_SP_EN
      add(2, 4'b0000, 4'b0010, 1, I, 2'b00, 1, 0, 4'b0000);
`endif
      run_all();

      // reset while moving up: motor must stop without a clock edge
      run_row(mk(1, 4'b1000, 4'b0010, 0, I, 2'b00, 1, 0, 4'b1000));
      run_row(mk(1, 4'b0000, 4'b0010, 0, U, 2'b01, 1, 1, 4'b1000));
      #2;
      reset = 1'b0;
      fc    = 4'b0000;
      #1;
      check("async_motor", 16'(motor), 16'h0);
      check("async_state", 16'(dbg_state), 16'(H));
      check("async_req",   16'(dbg_req), 16'h0);
      check("async_floor", 16'(floor), 16'h0);
      check("async_busy",  16'(busy), 16'h1);
      #2;
      reset = 1'b1;
      add(1, 4'b0000, 4'b0000, 0, H, 2'b10, 0, 1, 4'b0000);
      add(1, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0000);
      add(7, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0000);
      add(1, 4'b0000, 4'b0001, 0, I, 2'b00, 0, 0, 4'b0000);
`ifdef MONTACARGAS_SP_EN
      // overweight hold in IDLE: calls still latch, then dwell and go up
      add(1, 4'b0000, 4'b0001, 1, O, 2'b00, 0, 1, 4'b0000);
      add(1, 4'b0100, 4'b0001, 1, O, 2'b00, 0, 1, 4'b0100);
      add(6, 4'b0000, 4'b0001, 1, O, 2'b00, 0, 1, 4'b0100);
      add(1, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0100);
      add(7, 4'b0000, 4'b0001, 0, W, 2'b00, 0, 1, 4'b0100);
      add(1, 4'b0000, 4'b0001, 0, U, 2'b01, 0, 1, 4'b0100);
`endif
      run_all();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/montacargas_gen.md
# montacargas_gen

Parametrised freight-lift controller for FLOORS stops. It latches hall/car calls, serves them with collective up/down scheduling, and holds a door-dwell period at each stop. It also generates its own 2-digit common-cathode display scan, so no external scan clock is needed. It sits between the pushbuttons/limit switches and the motor driver plus display on the CPLD board, running from the 4 MHz board clock.

## Interface
- FLOORS, 4, number of stops (2..8)
- FW, 3, floor index width; must satisfy 2**FW >= FLOORS
- DWELL, 4000000, stop dwell in clk cycles (1 s at 4 MHz); minimum 1
- MUX_DIV, 33333, clk cycles per display digit slot (~60 Hz per digit)

- clk  in  1  board clock (4 MHz)
- reset  in  1  asynchronous, active-low; 0 = reset
- call  in  FLOORS  request buttons, bit i = floor i+1, active-high, pre-synchronised
- fc  in  FLOORS  limit switches, bit i high while car is at floor i+1
- sp  in  1  overweight sensor, active-high
- motor  out  2  00 stop, 01 up, 10 down; 11 never driven
- on  out  2  digit enables, active-low: 10 = right digit lit, 01 = left digit lit
- seg  out  7  segments g..a, g = MSB
- floor  out  FW  last confirmed floor index (0-based)
- busy  out  1  high in every state except IDLE

## Operation
- `req[FLOORS-1:0]` latches: `req[i]` is set by `call[i]` and cleared when the car stops at floor i.
- `fc` is valid only when one-hot. While fc is one-hot, `floor` takes the index of the set bit. Zero or multi-hot fc leaves `floor` unchanged.
- `ahead_up` = any `req` above `floor`; `ahead_dn` = any `req` below `floor`.
- States: HOMING, IDLE, UP, DOWN, DWELL, OVER.
- HOMING: motor=10. Goes to DWELL when `fc[0]` is set.
- IDLE: motor=00.
  - `req[floor]` set → clear it, go to DWELL.
  - Else `ahead_up` → UP.
  - Else `ahead_dn` → DOWN.
  - Up has priority when both are set; the car has no stored direction in IDLE.
- UP: motor=01. When fc is one-hot at index k:
  - `req[k]` set → stop, clear `req[k]`, go to DWELL.
  - k = FLOORS-1 → stop and go to DWELL regardless of `req`.
- DOWN: mirror of UP; k = 0 forces a stop.
- DWELL: motor=00, counter loads DWELL-1 on entry.
  - `call[floor]` during dwell reloads the counter and is not latched.
  - On expiry: continue in the last travel direction if requests remain ahead, else reverse if requests remain behind, else IDLE.
- OVER (only with MONTACARGAS_SP_EN): entered from IDLE or DWELL when sp=1, motor=00. `req` keeps latching. Exits to DWELL with the counter reloaded once sp=0.
- sp is ignored in UP, DOWN and HOMING.
- Display content:
  - Stopped (IDLE, DWELL): right digit = floor+1, left digit blank.
  - Moving: left digit = next stop, right digit blank.
  - HOMING: left digit = 1.
  - OVER: left = S (1101101), right = P (1110011).
- Digit codes:
  - 1 0000110
  - 2 1011011
  - 3 1001111
  - 4 1100110
  - 5 1101101
  - 6 1111101
  - 7 0000111
  - 8 1111111
  - blank 0000000
- Scan: `on` toggles every MUX_DIV cycles. `seg` carries the content of the enabled digit.

## Timing
- All outputs are registered.
- Reset values: motor=00, on=10, seg=0000000, floor=0, busy=1, req=0, state=HOMING.
- First clock after reset release: motor=10.
- `call` high at edge n → `req` bit set at n+1.
- fc one-hot at edge n → `floor` and the motor-stop decision take effect at n+1 (1-cycle latency).
- DWELL lasts exactly DWELL cycles from entry to the next-state decision.
- Simultaneous call and arrival at the same floor: the stop wins and the bit ends cleared.
- Simultaneous calls: all are latched.
- Reset asserted mid-travel: motor=00 asynchronously. After release the controller re-homes.

## Configuration
- MONTACARGAS_SP_EN defined: OVER state present; sp behaves as described under Operation.
- MONTACARGAS_SP_EN undefined: OVER is not synthesised, sp is unused, and the S/P display is never shown.

## Test plan
All scenarios use FLOORS=4, DWELL=8, MUX_DIV=4.
- Reset release with fc=0000, then fc=0001 → motor=10 until fc, then 00 next cycle, floor=0, DWELL 8 cycles, IDLE, busy=0.
- At floor 0, pulse call[3] → UP. Pass fc=0010 and 0100 without stopping, floor updates to 1 then 2. fc=1000 → motor=00, floor=3, req=0000.
- During UP toward floor 3, pulse call[1] and call[2]. Then:
  - stops at floor 2;
  - after dwell, continues to floor 3;
  - then DOWN to floor 1.
- In DWELL at floor 1, pulse call[1] at cycle 5 → dwell extends to 8 cycles after the pulse. req[1] stays 0.
- With SP_EN, sp=1 in IDLE at floor 0 → motor=00, seg alternates P/S with on. call[2] is latched. After sp=0: DWELL, then UP.
- Assert reset while motor=01 → motor=00 within the same cycle (async). After release, motor=10 (homing).
